// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_XLEN = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam logic [IFU_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INCR     = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_PEND     = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter and pending-redirect register with next-PC selection.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_sel_t         i_sel,
  input  logic            i_pend_wr,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pend_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_target;

  // Redirect targets are word-aligned by clearing the low two bits.
  assign w_target = {i_redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
    end else begin
      case (i_sel)
        PC_INCR:     r_pc <= r_pc + XLEN'(PC_STEP);
        PC_REDIRECT: r_pc <= w_target;
        PC_PEND:     r_pc <= r_pend_pc;
        default:     r_pc <= r_pc;
      endcase
      if (i_pend_wr) r_pend_pc <= w_target;
    end
  end

  assign o_pc      = r_pc;
  assign o_pend_pc = r_pend_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, imem req/ack handshake, single-entry instruction register,
// stall handling and redirects (including redirects during an in-flight request).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [XLEN-1:0]     pc_out,
  output logic                instr_valid
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic            r_instr_valid;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pend_pc;
  logic            w_req;
  logic            w_load;
  logic            w_pend_wr;
  pc_sel_t         w_pc_sel;
  logic            w_consume;
  logic            w_can_issue;

  assign w_consume   = r_instr_valid & ~stall;
  assign w_can_issue = ~r_instr_valid | ~stall;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .i_sel         (w_pc_sel),
    .i_pend_wr     (w_pend_wr),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc),
    .o_pend_pc     (w_pend_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_load      = 1'b0;
    w_pend_wr   = 1'b0;
    w_pc_sel    = PC_HOLD;
    case (r_state)
      S_IDLE: begin
        w_req = w_can_issue & ~redirect;
        if (redirect) begin
          w_pc_sel = PC_REDIRECT;
        end else if (w_req && imem_ack) begin
          w_load   = 1'b1;
          w_pc_sel = PC_INCR;
        end else if (w_req) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          if (redirect) begin
            w_pc_sel = PC_REDIRECT;
          end else begin
            w_load   = 1'b1;
            w_pc_sel = PC_INCR;
          end
        end else if (redirect) begin
          w_pend_wr   = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The outstanding word is stale; keep the handshake alive until it returns.
        w_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          w_pc_sel    = redirect ? PC_REDIRECT : PC_PEND;
        end else if (redirect) begin
          w_pend_wr = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr       <= NOP_INSTR;
      r_pc_out      <= '0;
      r_instr_valid <= 1'b0;
    end else if (redirect) begin
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr       <= imem_rdata;
      r_pc_out      <= w_pc;
      r_instr_valid <= 1'b1;
    end else if (w_consume) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign imem_req    = w_req & ~reset;
  assign imem_addr   = w_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_W-1:0];
  assign pc_out      = r_pc_out;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_valid;

  int vectors;
  int miscompares;
  int lat;
  int r_wait;

  instruction_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks once the request has been held for 'lat' extra cycles; data = addr + 0x100.
  always_ff @(posedge clk) begin
    if (!imem_req || imem_ack) r_wait <= 0;
    else                       r_wait <= r_wait + 1;
  end

  always_comb begin
    imem_ack   = imem_req && (r_wait == lat);
    imem_rdata = imem_addr + 32'h100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    r_wait      = 0;
    lat         = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_instr", instr, 32'h13);
    chk("rst_opcode", {25'd0, opcode}, 32'h13);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Zero-wait streaming
    @(negedge clk);
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", {31'd0, instr_valid}, 32'd1);
    chk("c1_instr", instr, 32'h100);
    chk("c1_pc_out", pc_out, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c2_addr", imem_addr, 32'h8);
    chk("c2_instr", instr, 32'h104);
    chk("c2_pc_out", pc_out, 32'h4);
    next_cycle();

    // Stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr", instr, 32'h108);
      chk("stall_pc_out", pc_out, 32'h8);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'hC);
    next_cycle();

    // Slow memory, redirect while request outstanding
    lat = 2;
    @(negedge clk);
    chk("c7_instr", instr, 32'h10C);
    chk("c7_pc_out", pc_out, 32'hC);
    chk("c7_addr", imem_addr, 32'h10);
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("c8_req", {31'd0, imem_req}, 32'd1);
    chk("c8_addr", imem_addr, 32'h10);
    chk("c8_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    chk("flush_addr", imem_addr, 32'h10);
    chk("flush_instr", instr, 32'h13);
    next_cycle();
    @(negedge clk);
    chk("c10_addr", imem_addr, 32'h40);
    chk("c10_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("c11_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("c12_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("c13_valid", {31'd0, instr_valid}, 32'd1);
    chk("c13_instr", instr, 32'h140);
    chk("c13_pc_out", pc_out, 32'h40);
    chk("c13_addr", imem_addr, 32'h44);
    next_cycle();
    next_cycle();

    // Redirect coincident with ack, unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h83;
    @(negedge clk);
    chk("c15_addr", imem_addr, 32'h44);
    next_cycle();
    redirect = 1'b0;
    lat      = 0;
    @(negedge clk);
    chk("c16_addr", imem_addr, 32'h80);
    chk("c16_valid", {31'd0, instr_valid}, 32'd0);
    chk("c16_instr", instr, 32'h13);
    next_cycle();

    // Wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("c17_instr", instr, 32'h180);
    chk("c17_pc_out", pc_out, 32'h80);
    chk("c17_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    chk("c18_addr", imem_addr, 32'hFFFF_FFFC);
    chk("c18_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    lat = 2;
    @(negedge clk);
    chk("wrap_instr", instr, 32'h0000_00FC);
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    next_cycle();

    // Reset with a request in flight
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instr, 32'h13);
    chk("post_rst_pc_out", pc_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
